// File: rtl/fft_sample_loader.sv
// Streaming PCM front end that writes samples into ping-pong frame banks of the FFT sample RAM.
// Define FFT_LOADER_BITREV_EN to store each frame in bit-reversed (DIT) order instead of natural order.
module fft_sample_loader #(
  parameter int LOG2_N     = 10,
  parameter int ADDR_W     = 15,
  parameter int BANK0_BASE = 0,
  parameter int BANK1_BASE = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [15:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        address2,
  output logic [31:0]              writedata2,
  output logic                     write2,
  output logic                     chipselect2,
  output logic [3:0]               byteenable2,
  output logic                     frame_valid,
  output logic                     frame_bank,
  // "release" is a reserved keyword, so the engine's hand-back strobe is release_pulse
  input  logic                     release_pulse,
  input  logic                     release_bank,
  output logic [1:0]               bank_full,
  output logic [15:0]              drop_count
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  state_t            state, state_nxt;
  logic              cur_bank;
  logic [LOG2_N-1:0] count;
  logic [1:0]        bf_set, bf_clr, bank_full_nxt;
  logic              accept, last;
  logic              frame_vld_p0;
  logic              frame_bank_p0;

  function automatic logic [LOG2_N-1:0] idx(input logic [LOG2_N-1:0] c);
    logic [LOG2_N-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < LOG2_N; i++) r[i] = c[LOG2_N-1-i];
`else
    r = c;
`endif
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] bank_base(input logic b);
    return b ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign in_ready    = (state == FILL);
  assign byteenable2 = 4'hF;

  always_comb begin
    accept        = in_valid & in_ready;
    // Samples accepted while enable is low are written but never complete a frame
    last          = accept & enable & (&count);
    bf_set        = 2'b00;
    bf_clr        = 2'b00;
    if (last)          bf_set[cur_bank]     = 1'b1;
    if (release_pulse) bf_clr[release_bank] = 1'b1;
    bank_full_nxt = (bank_full & ~bf_clr) | bf_set;

    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = bank_full[cur_bank] ? STALL : FILL;
      FILL:    if (!enable) state_nxt = IDLE;
               else if (last && bank_full_nxt[~cur_bank]) state_nxt = STALL;
      STALL:   if (!enable) state_nxt = IDLE;
               else if (!bank_full[cur_bank]) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_bank      <= 1'b0;
      count         <= '0;
      bank_full     <= 2'b00;
      drop_count    <= 16'h0000;
      write2        <= 1'b0;
      chipselect2   <= 1'b0;
      address2      <= '0;
      writedata2    <= 32'h0;
      frame_vld_p0  <= 1'b0;
      frame_bank_p0 <= 1'b0;
      frame_valid   <= 1'b0;
      frame_bank    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bank_full <= bank_full_nxt;

      if (!enable)     count <= '0;
      else if (accept) count <= count + 1'b1;
      if (last) cur_bank <= ~cur_bank;

      if (in_valid && !in_ready && state != IDLE) drop_count <= sat_inc(drop_count);

      // stage p0: RAM port-2 write issue
      write2      <= accept;
      chipselect2 <= accept;
      if (accept) begin
        address2   <= bank_base(cur_bank) + ADDR_W'(idx(count));
        writedata2 <= {in_data[DATA_W-1:0], 16'h0000};
      end
      frame_vld_p0 <= last;
      if (last) frame_bank_p0 <= cur_bank;

      // stage p1: frame announce, one cycle after the final write lands
      frame_valid <= frame_vld_p0;
      if (frame_vld_p0) frame_bank <= frame_bank_p0;
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: streaming, ping-pong banks, stall/drop, enable drop, reset.
module tb_fft_sample_loader;

  localparam int LOG2_N = 10;
  localparam int N      = 1 << LOG2_N;
  localparam int ADDR_W = 15;
  localparam int B0     = 0;
  localparam int B1     = 1024;

  logic              clk = 1'b0;
  logic              reset, enable, in_valid, release_pulse, release_bank;
  logic [15:0]       in_data;
  logic              in_ready, write2, chipselect2, frame_valid, frame_bank;
  logic [ADDR_W-1:0] address2;
  logic [31:0]       writedata2;
  logic [3:0]        byteenable2;
  logic [1:0]        bank_full;
  logic [15:0]       drop_count;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int fv_base;
  logic last_fb = 1'b0;

  always #5 clk = ~clk;

  fft_sample_loader #(.LOG2_N(LOG2_N), .ADDR_W(ADDR_W), .BANK0_BASE(B0), .BANK1_BASE(B1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address2(address2), .writedata2(writedata2), .write2(write2),
    .chipselect2(chipselect2), .byteenable2(byteenable2), .frame_valid(frame_valid),
    .frame_bank(frame_bank), .release_pulse(release_pulse), .release_bank(release_bank),
    .bank_full(bank_full), .drop_count(drop_count)
  );

  always @(posedge clk) begin
    if (frame_valid) begin
      fv_cnt  <= fv_cnt + 1;
      last_fb <= frame_bank;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_idx(input int k);
    int r;
`ifdef FFT_LOADER_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG2_N; b++) if (k[b]) r = r | (1 << (LOG2_N - 1 - b));
`else
    r = k;
`endif
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample; the loader must be ready and issue the write on the next cycle
  task automatic push(input string tag, input int k, input int base, input logic [15:0] d);
    logic rdy;
    logic [63:0] exp;
    in_valid = 1'b1;
    in_data  = d;
    rdy      = in_ready;
    tick();
    in_valid = 1'b0;
    exp = {14'h0, 1'b1, 1'b1, 1'b1, ADDR_W'(base + exp_idx(k)), d, 16'h0000};
    check(tag, {14'h0, rdy, write2, chipselect2, address2, writedata2}, exp);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    release_pulse = 1'b0; release_bank = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_write2", write2, 0);
    check("rst_cs2", chipselect2, 0);
    check("rst_addr2", address2, 0);
    check("rst_wdata2", writedata2, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_fbank", frame_bank, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_drop", drop_count, 0);
    check("byteenable", byteenable2, 4'hF);

    reset = 1'b0; enable = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      push("frameA", k, B0, 16'(k));
`ifdef FFT_LOADER_BITREV_EN
      if (k == 1)    check("bitrev_k1", address2, 512);
      if (k == 3)    check("bitrev_k3", address2, 768);
      if (k == 1022) check("bitrev_k1022", address2, 511);
`endif
    end
    check("fv_not_early", frame_valid, 0);
    check("full_after_A", bank_full, 2'b01);
    push("frameB0_first", 0, B1, 16'd1024);
    check("fv_A", frame_valid, 1);
    check("fbank_A", frame_bank, 0);
    for (int k = 1; k < N; k++) begin
      if (k == 100) begin release_pulse = 1'b1; release_bank = 1'b1; end
      push("frameB1", k, B1, 16'(1024 + k));
      release_pulse = 1'b0;
      if (k == 100) check("rel_not_full_ignored", bank_full, 2'b01);
    end
    check("both_full", bank_full, 2'b11);
    check("stall_not_ready", in_ready, 0);

    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    check("drop_count_5", drop_count, 5);
    check("fv_count_2", fv_cnt, 2);
    check("fbank_B1", last_fb, 1);

    release_pulse = 1'b1; release_bank = 1'b0;
    tick();
    release_pulse = 1'b0;
    check("release_clears", bank_full, 2'b10);
    tick();
    check("ready_after_release", in_ready, 1);

    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin release_pulse = 1'b1; release_bank = 1'b1; end
      push("frameC0", k, B0, 16'(2000 + k));
      release_pulse = 1'b0;
    end
    check("set0_clr1", bank_full, 2'b01);
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin release_pulse = 1'b1; release_bank = 1'b0; end
      push("frameD1", k, B1, 16'(2000 + k));
      release_pulse = 1'b0;
    end
    check("set1_clr0", bank_full, 2'b10);
    check("no_stall", in_ready, 1);

    for (int k = 0; k < 300; k++) push("partial", k, B0, 16'(5000 + k));
    enable = 1'b0;
    tick();
    check("idle_not_ready", in_ready, 0);
    tick();
    check("write_one_cycle", write2, 0);
    check("full_kept", bank_full, 2'b10);
    fv_base = fv_cnt;
    enable = 1'b1;
    tick();
    for (int k = 0; k < N; k++) push("restart", k, B0, 16'(3000 + k));
    repeat (3) tick();
    check("restart_one_fv", fv_cnt - fv_base, 1);
    check("restart_fbank", last_fb, 0);
    check("restart_full", bank_full, 2'b11);

    reset = 1'b1;
    tick();
    check("mid_rst_full", bank_full, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_addr", address2, 0);
    check("mid_rst_wdata", writedata2, 0);

    reset = 1'b0;
    tick();
    fv_base = fv_cnt;
    for (int k = 0; k < N; k++) push("prerst", k, B0, 16'(4000 + k));
    reset = 1'b1;
    tick();
    check("pend_rst_fv", frame_valid, 0);
    check("pend_rst_write", write2, 0);
    check("pend_rst_full", bank_full, 0);
    repeat (2) tick();
    check("pend_rst_no_fv", fv_cnt - fv_base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
